// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, with bo the borrow out of this bit.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock through a single full subtractor.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int DATA_WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  bin,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic                  ovf,
`endif
  output logic                  bout
);

  // Counter is wide enough to hold DATA_WIDTH itself, so it cannot wrap mid-operation.
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  brw_q, brw_d;
  logic                  bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic                  ovf_q, ovf_d;
`endif

  logic fs_d;
  logic fs_bo;
  logic load;
  logic last_bit;

  assign load     = (state_q != RUN) && start;
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_W'(DATA_WIDTH - 1));

  full_subtractor u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (brw_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next-state: operands shift right, result bits enter at the MSB.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    brw_d  = brw_q;
    diff_d = diff_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (load) begin
      a_d   = a;
      b_d   = b;
      brw_d = bin;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      brw_d = fs_bo;
      sh_d  = {fs_d, sh_q[DATA_WIDTH-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
      if (last_bit) begin
        diff_d = {fs_d, sh_q[DATA_WIDTH-1:1]};
        bout_d = fs_bo;
`ifdef SERIAL_SUB_OVF_EN
        // On the last bit a_q[0]/b_q[0] are the operand sign bits.
        ovf_d  = (a_q[0] ^ b_q[0]) & (fs_d ^ a_q[0]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      brw_q  <= brw_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the operand and result width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin one subtraction; sampled only when not busy.
REQ-005 The block SHALL have ports a and b, input, DATA_WIDTH bits each: the minuend and the subtrahend, captured with start.
REQ-006 The block SHALL have port bin, input, 1 bit: the borrow-in, captured with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the result becomes valid.
REQ-009 The block SHALL have port diff, output, DATA_WIDTH bits: the last completed difference.
REQ-010 The block SHALL have port bout, output, 1 bit: the last completed borrow-out.

Function
REQ-011 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 IDLE or DONE with start=1 SHALL capture a, b and bin, clear the bit counter and go to RUN at the next edge.
REQ-013 RUN SHALL process one bit per cycle, LSB first, through one full subtractor.
- The borrow is carried in a register between bits.
- Result bits are shifted into an internal shift register.
REQ-014 After exactly DATA_WIDTH RUN cycles the FSM SHALL go to DONE.
- done=1 is asserted for exactly one cycle.
- The start sample edge to the done-high cycle spans DATA_WIDTH+1 clock cycles.
REQ-015 DONE without start SHALL return to IDLE at the next edge; DONE with start SHALL go directly to RUN (back-to-back operation, no idle cycle).
REQ-016 busy SHALL be 1 exactly in RUN; start while busy SHALL be ignored, and a, b and bin changes during RUN SHALL have no effect.
REQ-017 diff and bout SHALL update only on entry to DONE and SHALL otherwise hold their values, including throughout a following RUN.
REQ-018 diff SHALL equal (a - b - bin) mod 2^DATA_WIDTH.
REQ-019 bout SHALL be 1 iff a < b + bin, comparing unsigned and at full precision.
REQ-020 The bit counter SHALL be $clog2(DATA_WIDTH+1) bits wide, so that it never wraps before completion.

Reset
REQ-021 rst=1 at an edge SHALL force IDLE, and SHALL set busy, done, diff and bout (and ovf when present) to 0, and SHALL clear the counter, the borrow and the shift register.
REQ-022 rst asserted mid-RUN SHALL abort the operation with no done pulse; rst takes priority over start in the same cycle.

Configuration
REQ-023 With macro SERIAL_SUB_OVF_EN defined, the block SHALL add output port ovf, 1 bit: signed two's-complement overflow of a - b - bin.
- ovf is updated and held under the same rules as diff.
- ovf = (a[MSB] != b[MSB]) and (diff[MSB] != a[MSB]).
REQ-024 Without SERIAL_SUB_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 Package serial_sub_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default-width constant (8).
REQ-026 The one-bit stage SHALL be sub-module full_subtractor.
- Ports: x, y, bi, d, bo.
- d = x^y^bi.
- bo = (~x&y) | (~(x^y)&bi).

Verification (DATA_WIDTH=8)
REQ-027 start with a=0x50, b=0x30, bin=0 -> diff=0x20, bout=0; done high 9 cycles after start; busy high for 8 cycles.
REQ-028 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; then a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1.
REQ-029 Two operations back-to-back, with start held through DONE, (0x10-0x01, then 0x05-0x07) -> diff=0x0F then 0xFE, bout=0 then 1, and no idle cycle between them.
- A start pulse during RUN, and operand changes during RUN, are ignored.
REQ-030 rst asserted 4 cycles into RUN -> no done pulse; all outputs 0 on the next cycle; the next start completes normally.
REQ-031 With SERIAL_SUB_OVF_EN: 0x80-0x01 -> diff=0x7F, ovf=1; 0x7F-0xFF -> diff=0x80, ovf=1; 0x05-0x03 -> ovf=0.
REQ-032 Exhaustive sweep of all 2^17 combinations of a, b and bin -> diff and bout match the reference model on every done pulse; zero mismatches reported.
